// File: rtl/cpu_pipe_pkg.sv
// Shared encodings for the 16-bit CPU pipeline.
// Instruction classes, field positions and sequencer states.
package cpu_pipe_pkg;

  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_I  = 2'b01;
  localparam logic [1:0] OP_BR = 2'b10;

  localparam logic [4:0]  FN_MUL = 5'b00011;
  localparam logic [7:0]  LD_LOW = 8'h01;
  localparam logic [15:0] NOP    = 16'h0000;

  localparam int CLS_HI = 15;
  localparam int CLS_LO = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 11;
  localparam int SR1_HI = 10;
  localparam int SR1_LO = 8;
  localparam int SR2_HI = 7;
  localparam int SR2_LO = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MULW  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_decode.sv
// ID/EX instruction decode for the pipeline sequencer.
// Flags ld/mul in EX and load-use hazards against ID.
module hazard_decode
  import cpu_pipe_pkg::*;
(
  input  logic [15:0] id_ir,
  input  logic [15:0] ex_ir,
  output logic        is_ld_ex,
  output logic        is_mul_ex,
  output logic        use_hz
);

  logic [1:0] ex_cls;
  logic [1:0] id_cls;
  logic [2:0] ex_rd;
  logic       rd_sr1;
  logic       rd_sr2;
  logic       hit1;
  logic       hit2;

  assign ex_cls = ex_ir[CLS_HI:CLS_LO];
  assign id_cls = id_ir[CLS_HI:CLS_LO];
  assign ex_rd  = ex_ir[RD_HI:RD_LO];

  assign is_ld_ex  = (ex_ir != NOP) &&
                     (ex_cls == OP_R) &&
                     (ex_ir[7:0] == LD_LOW);
  assign is_mul_ex = (ex_cls == OP_R) &&
                     (ex_ir[4:0] == FN_MUL);

  // Immediate class and the unused class read no registers.
  assign rd_sr1 = (id_cls != OP_I) && (id_cls != 2'b11);
  assign rd_sr2 = (id_cls == OP_R);

  assign hit1 = rd_sr1 && (id_ir[SR1_HI:SR1_LO] == ex_rd);
  assign hit2 = rd_sr2 && (id_ir[SR2_HI:SR2_LO] == ex_rd);

  assign use_hz = is_ld_ex && (id_ir != NOP) && (hit1 || hit2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, MUL occupancy, branch flush.
// Drives advance, PC write, bubble and IF/ID flush.
module pipeline_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int MUL_LAT   = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [15:0] id_ir,
  input  logic [15:0] ex_ir,
  input  logic        br_taken,
  output logic        load,
  output logic        pc_we,
  output logic        bubble,
  output logic        flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] M_INIT =
    (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
  localparam logic [1:0] F_INIT =
    (FLUSH_CYC > 1) ? 2'(FLUSH_CYC - 2) : 2'd0;

  state_t     st;
  state_t     nxt;
  logic [3:0] mcnt;
  logic [3:0] mcnt_n;
  logic [1:0] fcnt;
  logic [1:0] fcnt_n;
  logic       is_ld_ex;
  logic       is_mul_ex;
  logic       use_hz;
  logic       ld_hz;

  hazard_decode u_dec (
    .id_ir     (id_ir),
    .ex_ir     (ex_ir),
    .is_ld_ex  (is_ld_ex),
    .is_mul_ex (is_mul_ex),
    .use_hz    (use_hz)
  );

  assign ld_hz = is_ld_ex && use_hz;
  assign state = st;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      st   <= RUN;
      mcnt <= '0;
      fcnt <= '0;
    end else begin
      st   <= nxt;
      mcnt <= mcnt_n;
      fcnt <= fcnt_n;
    end
  end

  always_comb begin
    nxt    = st;
    mcnt_n = mcnt;
    fcnt_n = fcnt;
    load   = 1'b1;
    pc_we  = 1'b1;
    bubble = 1'b0;
    flush  = 1'b0;
    unique case (st)
      RUN: begin
        if (br_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (FLUSH_CYC > 1) begin
            nxt    = FLUSH;
            fcnt_n = F_INIT;
          end
        end else if (is_mul_ex && (MUL_LAT > 1)) begin
          load   = 1'b0;
          pc_we  = 1'b0;
          nxt    = MULW;
          mcnt_n = M_INIT;
        end else if (ld_hz) begin
          pc_we  = 1'b0;
          bubble = 1'b1;
        end
      end
      MULW: begin
        if (mcnt != 4'd0) begin
          load   = 1'b0;
          pc_we  = 1'b0;
          mcnt_n = mcnt - 4'd1;
        end else begin
          // Release cycle: mul still sits in EX, so no re-trigger.
          nxt = RUN;
          if (ld_hz) begin
            pc_we  = 1'b0;
            bubble = 1'b1;
          end
        end
      end
      FLUSH: begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (fcnt == 2'd0) nxt = RUN;
        else fcnt_n = fcnt - 2'd1;
      end
      default: nxt = RUN;
    endcase
    if (!RSTN) begin
      load   = 1'b1;
      pc_we  = 1'b1;
      bubble = 1'b0;
      flush  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) stall_cnt <= '0;
    else if (!load && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// Three configurations share one stimulus stream.
module tb_pipeline_hazard_ctrl;

  localparam logic [15:0] LD3    = 16'h1801;
  localparam logic [15:0] ADD_S1 = 16'h0B40;
  localparam logic [15:0] ADD_S2 = 16'h0A60;
  localparam logic [15:0] LI     = 16'h4B05;
  localparam logic [15:0] BR_S2  = 16'h8060;
  localparam logic [15:0] BR_S1  = 16'h8300;
  localparam logic [15:0] LD0    = 16'h0001;
  localparam logic [15:0] MUL    = 16'h2143;
  localparam logic [15:0] BRX    = 16'h8000;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [15:0] id_ir = '0;
  logic [15:0] ex_ir = '0;
  logic        br_taken = 1'b0;

  logic        ld_o [3];
  logic        pc_o [3];
  logic        bub_o [3];
  logic        fl_o [3];
  logic [1:0]  st_o [3];
  logic [15:0] cnt_o [3];

  typedef struct {
    int          n;
    int          sel;
    logic [21:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic [21:0] act;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.MUL_LAT(4), .FLUSH_CYC(2)) u_main (
    .CLK(CLK), .RSTN(RSTN), .id_ir(id_ir), .ex_ir(ex_ir),
    .br_taken(br_taken), .load(ld_o[0]), .pc_we(pc_o[0]),
    .bubble(bub_o[0]), .flush(fl_o[0]), .state(st_o[0]),
    .stall_cnt(cnt_o[0])
  );

  pipeline_hazard_ctrl #(.MUL_LAT(1), .FLUSH_CYC(2)) u_lat1 (
    .CLK(CLK), .RSTN(RSTN), .id_ir(id_ir), .ex_ir(ex_ir),
    .br_taken(br_taken), .load(ld_o[1]), .pc_we(pc_o[1]),
    .bubble(bub_o[1]), .flush(fl_o[1]), .state(st_o[1]),
    .stall_cnt(cnt_o[1])
  );

  pipeline_hazard_ctrl #(.MUL_LAT(16), .FLUSH_CYC(1)) u_sat (
    .CLK(CLK), .RSTN(RSTN), .id_ir(id_ir), .ex_ir(ex_ir),
    .br_taken(br_taken), .load(ld_o[2]), .pc_we(pc_o[2]),
    .bubble(bub_o[2]), .flush(fl_o[2]), .state(st_o[2]),
    .stall_cnt(cnt_o[2])
  );

  task automatic step(
    input int          n,
    input logic        rst,
    input logic [15:0] id,
    input logic [15:0] ex,
    input logic        br,
    input int          sel,
    input logic [3:0]  lpbf,
    input logic [1:0]  st,
    input logic [15:0] cnt,
    input bit          chk
  );
    exp_t x;
    @(posedge CLK);
    #1;
    RSTN     = rst;
    id_ir    = id;
    ex_ir    = ex;
    br_taken = br;
    if (chk) begin
      x.n   = n;
      x.sel = sel;
      x.v   = {lpbf, st, cnt};
      q.push_back(x);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {ld_o[e.sel], pc_o[e.sel], bub_o[e.sel],
             fl_o[e.sel], st_o[e.sel], cnt_o[e.sel]};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL step%0d dut%0d: got ld/pc/bub/fl=%b st=%0d cnt=%h, want ld/pc/bub/fl=%b st=%0d cnt=%h",
                 e.n, e.sel, act[21:18], act[17:16], act[15:0],
                 e.v[21:18], e.v[17:16], e.v[15:0]);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, queue=%0d", q.size());
    $fatal(1);
  end

  initial begin
    logic [15:0] cm;
    logic        el;
    int          p;
    step(0,  0, 16'h0, MUL, 0, 0, 4'b1100, 2'd0, 16'd0, 1);
    step(1,  1, 16'h0, 16'h0, 0, 0, 4'b1100, 2'd0, 16'd0, 1);
    step(2,  1, ADD_S1, LD3, 0, 0, 4'b1010, 2'd0, 16'd0, 1);
    step(3,  1, ADD_S1, 16'h0, 0, 0, 4'b1100, 2'd0, 16'd0, 1);
    step(4,  1, ADD_S2, LD3, 0, 0, 4'b1010, 2'd0, 16'd0, 1);
    step(5,  1, LI, LD3, 0, 0, 4'b1100, 2'd0, 16'd0, 1);
    step(6,  1, BR_S2, LD3, 0, 0, 4'b1100, 2'd0, 16'd0, 1);
    step(7,  1, BR_S1, LD3, 0, 0, 4'b1010, 2'd0, 16'd0, 1);
    step(8,  1, 16'h0, LD0, 0, 0, 4'b1100, 2'd0, 16'd0, 1);
    step(9,  1, ADD_S1, MUL, 0, 0, 4'b0000, 2'd0, 16'd0, 1);
    step(10, 1, ADD_S1, MUL, 1, 0, 4'b0000, 2'd1, 16'd1, 1);
    step(11, 1, ADD_S1, MUL, 1, 0, 4'b0000, 2'd1, 16'd2, 1);
    step(12, 1, ADD_S1, MUL, 1, 0, 4'b1100, 2'd1, 16'd3, 1);
    step(13, 1, 16'h0, 16'h0, 0, 0, 4'b1100, 2'd0, 16'd3, 1);
    step(14, 1, 16'h0, MUL, 0, 0, 4'b0000, 2'd0, 16'd3, 1);
    step(15, 1, 16'h0, MUL, 0, 0, 4'b0000, 2'd1, 16'd4, 1);
    step(16, 1, 16'h0, MUL, 0, 0, 4'b0000, 2'd1, 16'd5, 1);
    step(17, 1, ADD_S1, LD3, 0, 0, 4'b1010, 2'd1, 16'd6, 1);
    step(18, 1, 16'h0, 16'h0, 0, 0, 4'b1100, 2'd0, 16'd6, 1);
    step(19, 1, ADD_S1, LD3, 1, 0, 4'b1111, 2'd0, 16'd6, 1);
    step(20, 1, ADD_S1, 16'h0, 1, 0, 4'b1111, 2'd2, 16'd6, 1);
    step(21, 1, 16'h0, 16'h0, 0, 0, 4'b1100, 2'd0, 16'd6, 1);
    step(22, 1, 16'h0, MUL, 1, 0, 4'b1111, 2'd0, 16'd6, 1);
    step(23, 1, 16'h0, 16'h0, 0, 0, 4'b1111, 2'd2, 16'd6, 1);
    step(24, 1, 16'h0, 16'h0, 0, 0, 4'b1100, 2'd0, 16'd6, 1);
    step(25, 1, 16'h0, MUL, 0, 0, 4'b0000, 2'd0, 16'd6, 1);
    step(26, 1, 16'h0, MUL, 0, 0, 4'b0000, 2'd1, 16'd7, 1);
    step(27, 1, 16'h0, MUL, 0, 0, 4'b0000, 2'd1, 16'd8, 1);
    @(negedge CLK);
    #2;
    RSTN = 1'b0;
    step(28, 0, 16'h0, MUL, 0, 0, 4'b1100, 2'd0, 16'd0, 1);
    step(29, 1, 16'h0, BRX, 1, 2, 4'b1111, 2'd0, 16'd0, 1);
    step(30, 1, 16'h0, 16'h0, 0, 2, 4'b1100, 2'd0, 16'd0, 1);
    cm = 16'd0;
    for (int i = 0; i < 69912; i++) begin
      p  = i % 16;
      el = (p == 15);
      if (i < 2)
        step(31 + i, 1, 16'h0, MUL, 0, 1, 4'b1100,
             2'd0, 16'd0, 1);
      else
        step(31 + i, 1, 16'h0, MUL, 0, 2, {el, el, 2'b00},
             (p == 0) ? 2'd0 : 2'd1, cm,
             (i < 20) || (i > 69880));
      if (!el && (cm != 16'hFFFF)) cm = cm + 16'd1;
    end
    @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
